// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes
module alu_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            validIn,
    output logic            readyIn,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            validOut,
    input  logic            readyOut,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;
    logic [2:0] op;
    logic neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [2*XLEN-1:0] acc, acc_nxt, mul_nxt, div_nxt, prod_fix;
    logic [CNT_W-1:0] count;
    logic is_div, sgn_a, sgn_b, s_a, s_b;
    logic div_zero, div_ovf, special, accept, last;
    logic [XLEN-1:0] abs_a, abs_b, special_res, quo, rem, quo_fix, rem_fix, calc_res;
    logic [XLEN:0] mul_sum, div_shift, div_diff;

    assign is_div      = funct3[2];
    assign sgn_a       = is_div ? ~funct3[0] : funct3[0] ^ funct3[1];
    assign sgn_b       = is_div ? ~funct3[0] : funct3[1:0] == 2'b01;
    assign s_a         = sgn_a & srcA[XLEN-1];
    assign s_b         = sgn_b & srcB[XLEN-1];
    assign abs_a       = s_a ? -srcA : srcA;
    assign abs_b       = s_b ? -srcB : srcB;
    assign div_zero    = srcB == '0;
    assign div_ovf     = ~funct3[0] & (srcA == {1'b1, {(XLEN-1){1'b0}}}) & (srcB == '1);
    assign special     = is_div & (div_zero | div_ovf);
    assign special_res = div_zero ? (funct3[1] ? srcA : '1) : (funct3[1] ? '0 : srcA);
    assign accept      = (state == IDLE) & validIn & ~flush;
    assign last        = (state == CALC) & (count == CNT_W'(1));

    // acc holds {partial product, multiplier} or {remainder, quotient}
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? mag_a : '0};
    assign mul_nxt   = {mul_sum, acc[XLEN-1:1]};
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_nxt   = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign acc_nxt   = op[2] ? div_nxt : mul_nxt;

    assign prod_fix = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
    assign quo      = acc_nxt[XLEN-1:0];
    assign rem      = acc_nxt[2*XLEN-1:XLEN];
    assign quo_fix  = (neg_a ^ neg_b) ? -quo : quo;
    assign rem_fix  = neg_a ? -rem : rem;
    assign calc_res = op[2] ? (op[1] ? rem_fix : quo_fix)
                            : (op[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state: flush wins over both accept and result handshake
    always_comb begin
        state_nxt = state;
        if (flush)                            state_nxt = IDLE;
        else if (state == IDLE && validIn)    state_nxt = special ? DONE : CALC;
        else if (last)                        state_nxt = DONE;
        else if (state == DONE && readyOut)   state_nxt = IDLE;
    end

    // handshake outputs decoded from state
    always_comb begin
        readyIn  = state == IDLE;
        validOut = state == DONE;
        busy     = state != IDLE;
    end

    // operand latch on accept, then one shift-add / shift-subtract step per CALC cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op    <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            mag_a <= '0;
            mag_b <= '0;
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            op    <= funct3;
            neg_a <= s_a;
            neg_b <= s_b;
            mag_a <= abs_a;
            mag_b <= abs_b;
            acc   <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
            count <= special ? '0 : CNT_W'(XLEN);
        end else if (state == CALC && !flush) begin
            acc   <= acc_nxt;
            count <= count - CNT_W'(1);
        end
    end

    // result only moves on the edge entering DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 result <= '0;
        else if (accept & special) result <= special_res;
        else if (last & ~flush)    result <= calc_res;
    end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed and randomized check of alu_muldiv_unit (XLEN 32 and 64) against a behavioural model
module tb_alu_muldiv_unit;
    logic clk = 0;
    logic reset = 1;
    logic validIn = 0, flush = 0, readyOut = 1, sel = 0, lit_on = 0;
    logic [2:0] funct3 = 0;
    logic [63:0] srcA = 0, srcB = 0, lit_exp = 0;
    logic rdy32, vo32, bsy32, rdy64, vo64, bsy64;
    logic [31:0] r32;
    logic [63:0] r64;
    logic rdy, vo, bsy;
    logic [63:0] res;
    int n_chk = 0, n_pass = 0, ncyc = 0, due = 0;
    bit mbusy = 0, shown = 0, mlit_on = 0;
    logic [63:0] mexp = 0, last_res = 0, mlit = 0;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .validIn(validIn & ~sel), .readyIn(rdy32), .funct3(funct3),
        .srcA(srcA[31:0]), .srcB(srcB[31:0]), .flush(flush), .validOut(vo32),
        .readyOut(readyOut), .result(r32), .busy(bsy32));
    alu_muldiv_unit #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .validIn(validIn & sel), .readyIn(rdy64), .funct3(funct3),
        .srcA(srcA), .srcB(srcB), .flush(flush), .validOut(vo64),
        .readyOut(readyOut), .result(r64), .busy(bsy64));

    assign rdy = sel ? rdy64 : rdy32;
    assign vo  = sel ? vo64 : vo32;
    assign bsy = sel ? bsy64 : bsy32;
    assign res = sel ? r64 : {32'b0, r32};

    // RISC-V M semantics via wide signed arithmetic
    function automatic logic [63:0] ref_res(input int xl, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] sa, sb, ua, ub, r;
        logic [63:0] m;
        m  = (xl == 32) ? 64'hFFFF_FFFF : '1;
        sa = (xl == 32) ? {{98{a[31]}}, a[31:0]} : {{66{a[63]}}, a};
        sb = (xl == 32) ? {{98{b[31]}}, b[31:0]} : {{66{b[63]}}, b};
        ua = (xl == 32) ? {98'b0, a[31:0]} : {66'b0, a};
        ub = (xl == 32) ? {98'b0, b[31:0]} : {66'b0, b};
        case (f)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> xl;
            3'd2: r = (sa * ub) >>> xl;
            3'd3: r = (ua * ub) >>> xl;
            3'd4: r = (ub == 0) ? -1 : sa / sb;
            3'd5: r = (ub == 0) ? -1 : ua / ub;
            3'd6: r = (ub == 0) ? ua : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return r[63:0] & m;
    endfunction

    function automatic bit is_special(input int xl, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m, mn;
        m  = (xl == 32) ? 64'hFFFF_FFFF : '1;
        mn = (xl == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        return f[2] && ((b & m) == 0 || (!f[0] && (a & m) == mn && (b & m) == m));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, ncyc, act, exp);
    endtask

    // single compare process: checks outputs every cycle, then advances the model
    always @(negedge clk or posedge reset) begin
        int xl;
        bit exp_v;
        xl = sel ? 64 : 32;
        if (reset) begin
            #1;
            chk("reset_readyIn", 64'(rdy), 64'd1);
            chk("reset_validOut", 64'(vo), 64'd0);
            chk("reset_busy", 64'(bsy), 64'd0);
            chk("reset_result", res, 64'd0);
            mbusy = 0;
            last_res = 0;
        end else begin
            exp_v = mbusy && ncyc >= due;
            chk("readyIn", 64'(rdy), 64'(!mbusy));
            chk("busy", 64'(bsy), 64'(mbusy));
            chk("validOut", 64'(vo), 64'(exp_v));
            if (exp_v) last_res = mexp;
            chk("result", res, last_res);
            if (exp_v && !shown && mlit_on) begin
                chk("model_pin", mexp, mlit);
                chk("result_lit", res, mlit);
            end
            if (exp_v) shown = 1;
            if (flush) mbusy = 0;
            else if (exp_v && readyOut) mbusy = 0;
            else if (!mbusy && validIn) begin
                mbusy = 1;
                shown = 0;
                mexp = ref_res(xl, funct3, srcA, srcB);
                due = ncyc + (is_special(xl, funct3, srcA, srcB) ? 1 : xl + 1);
                mlit_on = lit_on;
                mlit = lit_exp;
            end
        end
        ncyc++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b, input logic [63:0] lit);
        step();
        validIn = 1; funct3 = f; srcA = a; srcB = b; lit_on = 1; lit_exp = lit;
        step();
        validIn = 0; lit_on = 0;
        repeat ((sel ? 64 : 32) + 3) step();
    endtask

    function automatic logic [63:0] pick();
        case ($urandom % 8)
            0: return 64'd0;
            1: return '1;
            2: return sel ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
            3: return 64'($urandom % 16);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            validIn  = ($urandom % 4) != 0;
            funct3   = 3'($urandom);
            srcA     = pick();
            srcB     = pick();
            readyOut = ($urandom % 4) != 0;
            flush    = ($urandom % 50) == 0;
        end
        step();
        validIn = 0; flush = 1; readyOut = 1;
        step();
        flush = 0;
    endtask

    initial begin
        repeat (3) step();
        reset = 0;
        op(3'd0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB);
        op(3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000);
        op(3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE);
        op(3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        op(3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD);
        op(3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF);
        op(3'd5, 64'd100, 64'd7, 64'd14);
        op(3'd7, 64'd100, 64'd7, 64'd2);
        op(3'd4, 64'd5, 64'd0, 64'hFFFF_FFFF);
        op(3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF);
        op(3'd6, 64'd5, 64'd0, 64'd5);
        op(3'd7, 64'd5, 64'd0, 64'd5);
        op(3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000);
        op(3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
        // backpressure in DONE while a new request is waiting
        step();
        validIn = 1; funct3 = 3'd5; srcA = 64'd100; srcB = 64'd7; lit_on = 1; lit_exp = 64'd14; readyOut = 0;
        step();
        funct3 = 3'd0; srcA = 64'd3; srcB = 64'd5; lit_on = 0;
        repeat (42) step();
        validIn = 0; readyOut = 1;
        repeat (3) step();
        // flush with 12 iterations left
        step();
        validIn = 1; funct3 = 3'd0; srcA = 64'd123; srcB = 64'd456;
        step();
        validIn = 0;
        repeat (20) step();
        flush = 1;
        step();
        flush = 0;
        repeat (40) step();
        // request alongside flush in IDLE is dropped
        step();
        validIn = 1; flush = 1;
        step();
        validIn = 0; flush = 0;
        repeat (3) step();
        // async reset pulse between clock edges mid-CALC
        step();
        validIn = 1; funct3 = 3'd4; srcA = 64'd1000; srcB = 64'd3;
        step();
        validIn = 0;
        repeat (10) step();
        reset = 1;
        #2;
        reset = 0;
        repeat (3) step();
        rand_phase(3000);
        reset = 1;
        repeat (2) step();
        reset = 0; sel = 1;
        op(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        op(3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
        op(3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
        op(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        op(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1);
        op(3'd5, 64'd100, 64'd7, 64'd14);
        op(3'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
        rand_phase(3000);
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Iterative RV32M/RV64M multiply-divide execution unit. It is the parametrised successor to the single-cycle ALU decode path. It decodes funct3 for the eight M-extension ops (selected when funct7 = 0000001) and computes the result over multiple cycles using a shift-add / restoring-divide datapath. Valid/ready handshakes connect it to the core, so the pipeline can stall on it or flush it.

Parameters:
XLEN, 32, operand/result width; legal values 32 and 64.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
validIn  input  1  request valid.
readyIn  output  1  unit can accept a request (high only in IDLE).
funct3  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
srcA  input  XLEN  rs1 (multiplicand / dividend).
srcB  input  XLEN  rs2 (multiplier / divisor).
flush  input  1  abort any in-flight op.
validOut  output  1  result valid.
readyOut  input  1  consumer accepts result.
result  output  XLEN  op result.
busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, any state): state=IDLE; readyIn=1, validOut=0, busy=0, result=0, counter=0, internal registers=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On validIn & readyIn, latch funct3, srcA, srcB, operand signs, and magnitudes.
  - Signedness of the magnitudes: signed for MULH (both operands), MULHSU (srcA only), DIV/REM (both); unsigned otherwise.
  - Divide special cases (funct3[2]=1):
    - srcB==0: DIV/DIVU give all-ones; REM/REMU give srcA.
    - Signed overflow (DIV/REM with srcA = most-negative, srcB = all-ones): DIV gives srcA, REM gives 0.
    - Special cases load result and go directly to DONE. validOut is visible 1 cycle after the accept edge.
  - Otherwise go to CALC with counter=XLEN.
- CALC:
  - Each cycle performs one iteration and decrements counter.
  - Multiply: 2*XLEN-bit unsigned shift-add of the magnitudes.
  - Divide: restoring shift-subtract giving XLEN-bit quotient and remainder.
  - On the iteration where counter reaches 0, apply sign fixup and load result, then go to DONE.
  - Sign fixup:
    - Multiply product is negated if the operand signs differ (signed operands only).
    - Quotient is negated if the dividend and divisor signs differ.
    - Remainder takes the sign of the dividend.
  - Result selection:
    - MUL returns the low XLEN bits of the product.
    - MULH/MULHSU/MULHU return the high XLEN bits.
  - validOut rises exactly XLEN cycles after the accept edge.
- DONE:
  - validOut=1; result held stable until validOut & readyOut.
  - On that handshake edge go to IDLE, drop validOut, and set readyIn=1.
  - No back-to-back accept in the same cycle as the result handshake: readyIn is 0 in DONE.
- flush:
  - Any state goes to IDLE on the next edge; validOut drops, and the pending result is discarded with no handshake.
  - flush has priority over the accept and over the result handshake.
  - A request presented with validIn in the same cycle as flush is not accepted.
- Inputs are ignored outside IDLE; srcA/srcB/funct3 may change freely while busy.
- Async reset mid-CALC: the op is lost, and outputs return to reset values immediately (no clock required).
- result changes only on the edge entering DONE or on reset.

Test Plan:
- XLEN=32, MUL srcA=7, srcB=0xFFFFFFFD -> result 0xFFFFFFEB; validOut exactly 32 cycles after accept.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Divide by zero: DIV/DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. In all these cases validOut appears 1 cycle after accept.
- Backpressure: hold readyOut=0 for 10 cycles in DONE -> result stable, readyIn=0, and new validIn is ignored. Then readyOut=1 -> returns to IDLE next edge with readyIn=1.
- Abort: flush asserted mid-CALC (counter=12) -> IDLE next edge, validOut never asserts. Async reset pulse mid-CALC with no clock edge -> validOut=0 and readyIn=1 immediately. Rerun with XLEN=64 on the MUL/DIV cases -> 64-cycle latency.
